ch_adv_tx: RTL

Transmit-side counterpart to the known-cluster-head recorder. It serializes cluster-head advertisement packets onto the node's outgoing word stream using a valid/ready handshake. There are two packet types:
- CHE: the node announces itself as a cluster head.
- INV: the node relays its chosen CH with hops+1.
Each packet is six 16-bit words. The CH ID, hops and Q-value fields are exactly the ones the receiving knownCH logic records.

---
 rtl/ch_adv_tx.sv | 124 ++++++++++++
 1 files changed

// File: rtl/ch_adv_tx.sv
// ch_adv_tx: serializes six-word cluster-head advertisement packets (CHE/INV)
// onto a valid/ready word stream. All packet fields are captured when a
// request is accepted, so later input changes never alter a packet in flight.
module ch_adv_tx #(
    parameter int unsigned WORD_WIDTH = 16,
    parameter int unsigned MAX_HOPS   = 15,
    parameter int unsigned PKT_LEN    = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  send_CHE,
    input  logic                  send_INV,
    input  logic                  abort,
    input  logic [WORD_WIDTH-1:0] my_ID,
    input  logic [WORD_WIDTH-1:0] my_QValue,
    input  logic [WORD_WIDTH-1:0] chosenCH,
    input  logic [WORD_WIDTH-1:0] hopsfromCH,
    input  logic                  tx_ready,
    output logic                  tx_valid,
    output logic [WORD_WIDTH-1:0] tx_data,
    output logic                  tx_last,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [7:0]            seq_num
);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t                state_q, state_d;
    logic [2:0]            idx_q, idx_d;
    logic [7:0]            seq_q, seq_d;
    logic                  err_q, err_d;
    logic [WORD_WIDTH-1:0] pkt_q [PKT_LEN];
    logic [WORD_WIDTH-1:0] pkt_d [PKT_LEN];

    logic                  inv_ok;
    logic                  inv_bad;
    logic                  take_inv;
    logic [3:0]            pkt_type;
    logic [WORD_WIDTH-1:0] w0, w2, w3;

    // Request qualification, and the packet words that would be captured this cycle
    always_comb begin
        inv_ok   = (chosenCH != '0) && (hopsfromCH < WORD_WIDTH'(MAX_HOPS));
        inv_bad  = send_INV && !send_CHE && !inv_ok;
        take_inv = send_INV && !send_CHE && inv_ok;
        pkt_type = take_inv ? 4'h2 : 4'h1;
        w0       = WORD_WIDTH'({pkt_type, 4'(PKT_LEN), seq_q});
        w2       = take_inv ? chosenCH : my_ID;
        w3       = take_inv ? (hopsfromCH + WORD_WIDTH'(1)) : '0;
    end

    // Next-state logic: accept/reject in IDLE, advance on handshake, abort override
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        seq_d   = seq_q;
        err_d   = 1'b0;
        pkt_d   = pkt_q;
        case (state_q)
            IDLE: begin
                if (send_CHE || take_inv) begin
                    pkt_d[0] = w0;
                    pkt_d[1] = my_ID;
                    pkt_d[2] = w2;
                    pkt_d[3] = w3;
                    pkt_d[4] = my_QValue;
                    pkt_d[5] = w0 ^ my_ID ^ w2 ^ w3 ^ my_QValue;
                    idx_d    = '0;
                    state_d  = SEND;
                end else if (inv_bad) begin
                    err_d = 1'b1;
                end
            end
            SEND: begin
                if (tx_ready) begin
                    if (idx_q == 3'(PKT_LEN - 1)) begin
                        idx_d   = '0;
                        seq_d   = seq_q + 8'd1;
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // abort discards any request or progress made this cycle
        if (abort) begin
            state_d = IDLE;
            idx_d   = '0;
            seq_d   = seq_q;
            err_d   = 1'b0;
        end
    end

    // State and packet registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            seq_q   <= '0;
            err_q   <= 1'b0;
            for (int unsigned i = 0; i < PKT_LEN; i++) pkt_q[i] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            seq_q   <= seq_d;
            err_q   <= err_d;
            pkt_q   <= pkt_d;
        end
    end

    assign tx_valid = (state_q == SEND);
    assign tx_data  = tx_valid ? pkt_q[idx_q] : '0;
    assign tx_last  = tx_valid && (idx_q == 3'(PKT_LEN - 1));
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign err      = err_q;
    assign seq_num  = seq_q;

endmodule
